// File: rtl/seq_piso_serializer.sv
// seq_piso_serializer
// Parallel-in/serial-out serializer feeding the synchronous-reset delay line.
// Words arrive over a valid/ready handshake and leave one bit per shift_en
// advance on the registered output q, with framing strobes and a wrapping
// completed-word counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no word in flight; q = IDLE_LEVEL, ready for a new word
//   ST_SHIFT | a word is on q; idx is the emitted bit index (0 = first)
//
// A new word may be accepted on the same edge that retires the last bit of
// the current one, which gives gap-free streaming at one bit per cycle.
module seq_piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  output logic             q,
  output logic             q_valid,
  output logic             q_first,
  output logic             q_last,
  output logic [15:0]      word_cnt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    idx_inc;
  logic             q_q, q_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             last_adv;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sreg_shifted;

  // Handshake and data-path helpers derived from the current state.
  always_comb begin
    last_adv = (state_q == ST_SHIFT) && (idx_q == IDX_LAST) && shift_en;
    in_ready = reset && ((state_q == ST_IDLE) || last_adv);
    accept   = in_valid && in_ready;
    idx_inc  = idx_q + 1'b1;
    if (MSB_FIRST) begin
      first_bit    = in_data[WIDTH-1];
      next_bit     = sreg_q[WIDTH-2];
      sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      first_bit    = in_data[0];
      next_bit     = sreg_q[1];
      sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  // Next-state logic: hold by default, advance on shift_en, load on accept.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    q_d     = q_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // shift_en has no effect until a word is loaded
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (idx_q == IDX_LAST) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = ST_IDLE;
            sreg_d  = '0;
            idx_d   = '0;
            q_d     = IDLE_LEVEL;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            sreg_d  = sreg_shifted;
            idx_d   = idx_inc;
            q_d     = next_bit;
            first_d = 1'b0;
            last_d  = (idx_inc == IDX_LAST);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An accept overrides the retire path so the next word follows with no gap.
    if (accept) begin
      state_d = ST_SHIFT;
      sreg_d  = in_data;
      idx_d   = '0;
      q_d     = first_bit;
      valid_d = 1'b1;
      first_d = 1'b1;
      last_d  = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      q_q     <= IDLE_LEVEL;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q        = q_q;
  assign q_valid  = valid_q;
  assign q_first  = first_q;
  assign q_last   = last_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_seq_piso_serializer.sv
// Testbench for seq_piso_serializer: an MSB-first and an LSB-first instance
// share stimulus and are compared against a word-level reference model.
module tb_seq_piso_serializer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         shift_en;

  logic         rdy_m, q_m, qv_m, qf_m, ql_m;
  logic [15:0]  cnt_m;
  logic         rdy_l, q_l, qv_l, qf_l, ql_l;
  logic [15:0]  cnt_l;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: word in flight, count of bits already emitted, word count.
  bit           m_busy = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_pos  = 0;
  int           m_cnt  = 0;

  seq_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m),
    .in_data(in_data), .shift_en(shift_en), .q(q_m), .q_valid(qv_m),
    .q_first(qf_m), .q_last(ql_m), .word_cnt(cnt_m)
  );

  seq_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_l),
    .in_data(in_data), .shift_en(shift_en), .q(q_l), .q_valid(qv_l),
    .q_first(qf_l), .q_last(ql_l), .word_cnt(cnt_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic m_ready();
    return reset && (!m_busy || (m_pos == W - 1 && shift_en));
  endfunction

  function automatic logic m_q(input bit msb);
    if (!m_busy) return 1'b0;
    return msb ? m_word[W-1-m_pos] : m_word[m_pos];
  endfunction

  // Advance one clock edge and the model alongside it.
  task automatic tick();
    bit rdy;
    @(posedge clk);
    rdy = m_ready();
    if (!reset) begin
      m_busy = 1'b0; m_pos = 0; m_cnt = 0;
    end else begin
      if (m_busy && shift_en) begin
        if (m_pos == W - 1) begin
          m_cnt  = (m_cnt + 1) % 65536;
          m_busy = 1'b0;
        end else begin
          m_pos++;
        end
      end
      if (in_valid && rdy) begin
        m_busy = 1'b1; m_word = in_data; m_pos = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; shift_en = 1'b0; in_data = '0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 8'hFF; shift_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (rdy_m !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", rdy_m); end
      n_cmp++; if (rdy_l !== 1'b0) begin n_err++; $display("FAIL reset_ready_lsb: got %b want 0", rdy_l); end
      tick();
      n_cmp++; if (q_m !== 1'b0) begin n_err++; $display("FAIL reset_q: got %b want 0", q_m); end
      n_cmp++; if (qv_m !== 1'b0) begin n_err++; $display("FAIL reset_q_valid: got %b want 0", qv_m); end
      n_cmp++; if (cnt_m !== 16'd0) begin n_err++; $display("FAIL reset_word_cnt: got %0d want 0", cnt_m); end
    end
    reset = 1'b1;
  endtask

  task automatic test_single_msb();
    bit seq [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    do_reset();
    shift_en = 1'b1; in_data = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k == 0);
      #1;
      if (k == 0) begin
        n_cmp++; if (rdy_m !== 1'b1) begin n_err++; $display("FAIL single_ready_idle: got %b want 1", rdy_m); end
      end
      tick();
      n_cmp++; if (q_m !== seq[k]) begin n_err++; $display("FAIL single_q[%0d]: got %b want %b", k, q_m, seq[k]); end
      n_cmp++; if (qv_m !== 1'b1) begin n_err++; $display("FAIL single_q_valid[%0d]: got %b want 1", k, qv_m); end
      n_cmp++; if (qf_m !== (k == 0)) begin n_err++; $display("FAIL single_q_first[%0d]: got %b want %b", k, qf_m, k == 0); end
      n_cmp++; if (ql_m !== (k == 7)) begin n_err++; $display("FAIL single_q_last[%0d]: got %b want %b", k, ql_m, k == 7); end
      n_cmp++; if (q_l !== m_q(1'b0)) begin n_err++; $display("FAIL single_lsb_q[%0d]: got %b want %b", k, q_l, m_q(1'b0)); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (qv_m !== 1'b0) begin n_err++; $display("FAIL single_end_valid: got %b want 0", qv_m); end
    n_cmp++; if (q_m !== 1'b0) begin n_err++; $display("FAIL single_end_q: got %b want 0", q_m); end
    n_cmp++; if (cnt_m !== 16'd1) begin n_err++; $display("FAIL single_word_cnt: got %0d want 1", cnt_m); end
    n_cmp++; if (cnt_l !== 16'd1) begin n_err++; $display("FAIL single_word_cnt_lsb: got %0d want 1", cnt_l); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    shift_en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      in_valid = (k <= 8);
      in_data  = (k == 0) ? 8'hFF : 8'h00;
      #1;
      n_cmp++;
      if (rdy_m !== (k == 0 || k == 8 || k == 16)) begin
        n_err++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, rdy_m, (k == 0 || k == 8 || k == 16));
      end
      tick();
      if (k < 16) begin
        n_cmp++; if (qv_m !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, qv_m); end
        n_cmp++; if (q_m !== (k < 8)) begin n_err++; $display("FAIL b2b_q[%0d]: got %b want %b", k, q_m, k < 8); end
        n_cmp++; if (q_l !== (k < 8)) begin n_err++; $display("FAIL b2b_lsb_q[%0d]: got %b want %b", k, q_l, k < 8); end
      end else begin
        n_cmp++; if (qv_m !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %b want 0", qv_m); end
        n_cmp++; if (cnt_m !== 16'd2) begin n_err++; $display("FAIL b2b_word_cnt: got %0d want 2", cnt_m); end
      end
    end
  endtask

  task automatic test_stall();
    bit seq [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    do_reset();
    in_data = 8'h3C; in_valid = 1'b1; shift_en = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (q_m !== seq[0]) begin n_err++; $display("FAIL stall_q0: got %b want %b", q_m, seq[0]); end
    n_cmp++; if (qv_m !== 1'b1) begin n_err++; $display("FAIL stall_valid0: got %b want 1", qv_m); end
    for (int j = 1; j <= 16; j++) begin
      shift_en = (j % 2 == 0);
      tick();
      if (j < 16) begin
        n_cmp++; if (q_m !== seq[j/2]) begin n_err++; $display("FAIL stall_q[%0d]: got %b want %b", j, q_m, seq[j/2]); end
        n_cmp++; if (ql_m !== (j / 2 == 7)) begin n_err++; $display("FAIL stall_q_last[%0d]: got %b want %b", j, ql_m, j / 2 == 7); end
        n_cmp++; if (q_l !== m_q(1'b0)) begin n_err++; $display("FAIL stall_lsb_q[%0d]: got %b want %b", j, q_l, m_q(1'b0)); end
      end else begin
        n_cmp++; if (qv_m !== 1'b0) begin n_err++; $display("FAIL stall_end_valid: got %b want 0", qv_m); end
        n_cmp++; if (cnt_m !== 16'd1) begin n_err++; $display("FAIL stall_word_cnt: got %0d want 1", cnt_m); end
      end
    end
  endtask

  task automatic test_lsb();
    do_reset();
    shift_en = 1'b1; in_data = 8'h01;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k == 0);
      tick();
      n_cmp++; if (q_l !== (k == 0)) begin n_err++; $display("FAIL lsb_q[%0d]: got %b want %b", k, q_l, k == 0); end
      n_cmp++; if (qf_l !== (k == 0)) begin n_err++; $display("FAIL lsb_q_first[%0d]: got %b want %b", k, qf_l, k == 0); end
      n_cmp++; if (q_m !== m_q(1'b1)) begin n_err++; $display("FAIL lsb_msb_q[%0d]: got %b want %b", k, q_m, m_q(1'b1)); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (qv_l !== 1'b0) begin n_err++; $display("FAIL lsb_end_valid: got %b want 0", qv_l); end
    n_cmp++; if (cnt_l !== 16'd1) begin n_err++; $display("FAIL lsb_word_cnt: got %0d want 1", cnt_l); end
  endtask

  task automatic test_reset_mid();
    bit seq [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    shift_en = 1'b1; in_data = 8'hF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (q_m !== 1'b1) begin n_err++; $display("FAIL mid_third_bit: got %b want 1", q_m); end
    reset = 1'b0;
    tick();
    n_cmp++; if (q_m !== 1'b0) begin n_err++; $display("FAIL mid_q: got %b want 0", q_m); end
    n_cmp++; if (qv_m !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", qv_m); end
    n_cmp++; if (cnt_m !== 16'd0) begin n_err++; $display("FAIL mid_word_cnt: got %0d want 0", cnt_m); end
    reset = 1'b1; in_data = 8'h81;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k == 0);
      tick();
      n_cmp++; if (q_m !== seq[k]) begin n_err++; $display("FAIL mid_after_q[%0d]: got %b want %b", k, q_m, seq[k]); end
      n_cmp++; if (qf_m !== (k == 0)) begin n_err++; $display("FAIL mid_after_first[%0d]: got %b want %b", k, qf_m, k == 0); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (cnt_m !== 16'd1) begin n_err++; $display("FAIL mid_after_word_cnt: got %0d want 1", cnt_m); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset    = ($urandom_range(0, 39) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      shift_en = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
      #1;
      n_cmp++; if (rdy_m !== m_ready()) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, rdy_m, m_ready()); end
      n_cmp++; if (rdy_l !== m_ready()) begin n_err++; $display("FAIL rnd_ready_lsb[%0d]: got %b want %b", c, rdy_l, m_ready()); end
      tick();
      n_cmp++; if (q_m !== m_q(1'b1)) begin n_err++; $display("FAIL rnd_q[%0d]: got %b want %b", c, q_m, m_q(1'b1)); end
      n_cmp++; if (q_l !== m_q(1'b0)) begin n_err++; $display("FAIL rnd_q_lsb[%0d]: got %b want %b", c, q_l, m_q(1'b0)); end
      n_cmp++; if (qv_m !== m_busy) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, qv_m, m_busy); end
      n_cmp++; if (qf_m !== (m_busy && m_pos == 0)) begin n_err++; $display("FAIL rnd_first[%0d]: got %b want %b", c, qf_m, m_busy && m_pos == 0); end
      n_cmp++; if (ql_m !== (m_busy && m_pos == W - 1)) begin n_err++; $display("FAIL rnd_last[%0d]: got %b want %b", c, ql_m, m_busy && m_pos == W - 1); end
      n_cmp++; if (ql_l !== (m_busy && m_pos == W - 1)) begin n_err++; $display("FAIL rnd_last_lsb[%0d]: got %b want %b", c, ql_l, m_busy && m_pos == W - 1); end
      n_cmp++; if (cnt_m !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_word_cnt[%0d]: got %0d want %0d", c, cnt_m, m_cnt); end
      n_cmp++; if (cnt_l !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_word_cnt_lsb[%0d]: got %0d want %0d", c, cnt_l, m_cnt); end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; shift_en = 1'b0;
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_stall();
    test_lsb();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
